// File: rtl/instr_sequencer.sv
// Control-phase sequencer and instruction register for the 16-bit CPU.
// Optional single-step control is enabled by defining INSTR_SEQUENCER_STEP_EN.
module instr_sequencer #(
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RUN,
  input  logic [15:0]      instr_in,
  input  logic             E2,
`ifdef INSTR_SEQUENCER_STEP_EN
  input  logic             STEP,
  input  logic             STEP_MODE,
`endif
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic [15:0]      instr,
  output logic             halted,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC1,
    ST_EXEC2,
    ST_HALT
  } state_t;

  localparam logic [15:0] NOP_INSTR  = 16'h7C00;
  localparam logic [2:0]  FETCH_LAST = 3'(FETCH_LAT - 1);

  state_t     state, state_next;
  logic [2:0] fetch_cnt, fetch_cnt_next;
  logic       instr_load;
  logic       retire;
  logic       halt_set;
  logic       is_stp;
  logic       start;
  logic       keep_going;

  assign is_stp = (instr[15] == 1'b0) && (instr[14:9] == 6'b111111);

`ifdef INSTR_SEQUENCER_STEP_EN
  logic step_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) step_q <= 1'b0;
    else       step_q <= STEP;
  end

  // In step mode RUN cannot restart the machine; only a fresh STEP edge can.
  assign start      = STEP_MODE ? (STEP && !step_q) : RUN;
  assign keep_going = STEP_MODE ? 1'b0 : RUN;
`else
  assign start      = RUN;
  assign keep_going = RUN;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    fetch_cnt_next = 3'd0;
    instr_load     = 1'b0;
    retire         = 1'b0;
    halt_set       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_cnt == FETCH_LAST) begin
          instr_load = 1'b1;
          state_next = ST_EXEC1;
        end else begin
          fetch_cnt_next = fetch_cnt + 3'd1;
        end
      end
      ST_EXEC1: begin
        if (is_stp) begin
          retire     = 1'b1;
          halt_set   = 1'b1;
          state_next = ST_HALT;
        end else if (E2) begin
          state_next = ST_EXEC2;
        end else begin
          retire     = 1'b1;
          state_next = keep_going ? ST_FETCH : ST_IDLE;
        end
      end
      ST_EXEC2: begin
        retire     = 1'b1;
        state_next = keep_going ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      fetch_cnt   <= 3'd0;
      instr       <= NOP_INSTR;
      FETCH       <= 1'b0;
      EXEC1       <= 1'b0;
      EXEC2       <= 1'b0;
      halted      <= 1'b0;
      running     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state     <= state_next;
      fetch_cnt <= fetch_cnt_next;
      if (instr_load) instr <= instr_in;
      FETCH   <= (state_next == ST_FETCH);
      EXEC1   <= (state_next == ST_EXEC1);
      EXEC2   <= (state_next == ST_EXEC2);
      running <= (state_next != ST_IDLE) && (state_next != ST_HALT);
      if (halt_set) halted <= 1'b1;
      if ((state == ST_FETCH || state == ST_EXEC1 || state == ST_EXEC2) &&
          cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (retire && instr_count != '1)
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one instance at default parameters,
// one at CNT_W=4 / FETCH_LAT=3 for saturation and fetch-hold checks.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: FETCH_LAT=1, CNT_W=16
  logic        rst_a_n, run_a, e2_a;
  logic [15:0] instr_in_a;
  logic        fetch_a, exec1_a, exec2_a, halted_a, running_a;
  logic [15:0] instr_a, cyc_a, ins_a;

  // Instance b: FETCH_LAT=3, CNT_W=4
  logic        rst_b_n, run_b, e2_b;
  logic [15:0] instr_in_b;
  logic        fetch_b, exec1_b, exec2_b, halted_b, running_b;
  logic [15:0] instr_b;
  logic [3:0]  cyc_b, ins_b;

  logic        step_in = 1'b0;
  logic        step_mode_in = 1'b0;

  instr_sequencer #(.FETCH_LAT(1), .CNT_W(16)) dut_a (
    .CLK(clk), .RSTn(rst_a_n), .RUN(run_a), .instr_in(instr_in_a), .E2(e2_a),
`ifdef INSTR_SEQUENCER_STEP_EN
    .STEP(step_in), .STEP_MODE(step_mode_in),
`endif
    .FETCH(fetch_a), .EXEC1(exec1_a), .EXEC2(exec2_a), .instr(instr_a),
    .halted(halted_a), .running(running_a), .cycle_count(cyc_a), .instr_count(ins_a)
  );

  instr_sequencer #(.FETCH_LAT(3), .CNT_W(4)) dut_b (
    .CLK(clk), .RSTn(rst_b_n), .RUN(run_b), .instr_in(instr_in_b), .E2(e2_b),
`ifdef INSTR_SEQUENCER_STEP_EN
    .STEP(step_in), .STEP_MODE(step_mode_in),
`endif
    .FETCH(fetch_b), .EXEC1(exec1_b), .EXEC2(exec2_b), .instr(instr_b),
    .halted(halted_b), .running(running_b), .cycle_count(cyc_b), .instr_count(ins_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes packed as {FETCH, EXEC1, EXEC2}
  function automatic logic [2:0] strobes_a();
    return {fetch_a, exec1_a, exec2_a};
  endfunction

  logic [2:0]  exp_ph;
  logic [15:0] snap_instr, snap_cyc, snap_ins;

  initial begin
    rst_a_n = 1'b0; run_a = 1'b0; e2_a = 1'b0; instr_in_a = 16'h0000;
    rst_b_n = 1'b0; run_b = 1'b0; e2_b = 1'b0; instr_in_b = 16'h0A4B;
    tick(); tick();

    // Reset state
    check("rst_strobes", 32'(strobes_a()), 32'b000);
    check("rst_instr",   32'(instr_a), 32'h7C00);
    check("rst_cyc",     32'(cyc_a), 0);
    check("rst_ins",     32'(ins_a), 0);
    check("rst_halted",  32'(halted_a), 0);
    check("rst_running", 32'(running_a), 0);

    // Test 1: single-cycle ALU ops alternate FETCH / EXEC1
    rst_a_n = 1'b1; run_a = 1'b1; instr_in_a = 16'h0A4B; e2_a = 1'b0;
    tick();
    check("t1_first_fetch", 32'(strobes_a()), 32'b100);
    check("t1_running", 32'(running_a), 1);
    check("t1_instr_held", 32'(instr_a), 32'h7C00);
    for (int k = 2; k <= 11; k++) begin
      tick();
      exp_ph = (k % 2 == 0) ? 3'b010 : 3'b100;
      check($sformatf("t1_phase_%0d", k), 32'(strobes_a()), 32'(exp_ph));
      check($sformatf("t1_instr_%0d", k), 32'(instr_a), 32'h0A4B);
    end
    check("t1_cyc", 32'(cyc_a), 10);
    check("t1_ins", 32'(ins_a), 5);

    // Test 2: LOAD with E2 -> period-3 FETCH/EXEC1/EXEC2
    instr_in_a = 16'h8005; e2_a = 1'b1;
    for (int k = 12; k <= 17; k++) begin
      tick();
      case ((k - 12) % 3)
        0:       exp_ph = 3'b010;
        1:       exp_ph = 3'b001;
        default: exp_ph = 3'b100;
      endcase
      check($sformatf("t2_phase_%0d", k), 32'(strobes_a()), 32'(exp_ph));
    end
    check("t2_instr", 32'(instr_a), 32'h8005);
    check("t2_ins", 32'(ins_a), 7);
    check("t2_cyc", 32'(cyc_a), 16);

    // Test 4: drop RUN during EXEC1 of a LOAD
    tick();
    check("t4_exec1", 32'(strobes_a()), 32'b010);
    run_a = 1'b0;
    tick();
    check("t4_exec2_kept", 32'(strobes_a()), 32'b001);
    tick();
    check("t4_idle", 32'(strobes_a()), 32'b000);
    check("t4_not_running", 32'(running_a), 0);
    check("t4_ins", 32'(ins_a), 8);
    check("t4_cyc", 32'(cyc_a), 19);
    tick();
    check("t4_idle_hold", 32'(strobes_a()), 32'b000);
    check("t4_idle_cyc", 32'(cyc_a), 19);
    run_a = 1'b1;
    tick();
    check("t4_restart", 32'(strobes_a()), 32'b100);

    // Test 5: reset during EXEC2
    tick();
    tick();
    check("t5_in_exec2", 32'(strobes_a()), 32'b001);
    rst_a_n = 1'b0;
    tick();
    check("t5_strobes", 32'(strobes_a()), 32'b000);
    check("t5_instr", 32'(instr_a), 32'h7C00);
    check("t5_cyc", 32'(cyc_a), 0);
    check("t5_ins", 32'(ins_a), 0);
    check("t5_running", 32'(running_a), 0);

    // Test 3: STP with E2 forced high halts
    rst_a_n = 1'b1; run_a = 1'b1; instr_in_a = 16'h7E00; e2_a = 1'b1;
    tick();
    check("t3_fetch", 32'(strobes_a()), 32'b100);
    tick();
    check("t3_exec1", 32'(strobes_a()), 32'b010);
    tick();
    check("t3_halt_strobes", 32'(strobes_a()), 32'b000);
    check("t3_halted", 32'(halted_a), 1);
    check("t3_running", 32'(running_a), 0);
    check("t3_ins", 32'(ins_a), 1);
    check("t3_cyc", 32'(cyc_a), 2);
    check("t3_instr", 32'(instr_a), 32'h7E00);
    snap_instr = instr_a; snap_cyc = cyc_a; snap_ins = ins_a;
    for (int k = 0; k < 20; k++) begin
      run_a = ~run_a;
      tick();
    end
    check("t3_hold_strobes", 32'(strobes_a()), 32'b000);
    check("t3_hold_halted", 32'(halted_a), 1);
    check("t3_hold_running", 32'(running_a), 0);
    check("t3_hold_instr", 32'(instr_a), 32'h7E00);
    check("t3_hold_cyc", 32'(cyc_a), 2);
    check("t3_hold_ins", 32'(ins_a), 1);

    // Test 6: FETCH_LAT=3, CNT_W=4, saturation
    rst_b_n = 1'b1; run_b = 1'b1; instr_in_b = 16'h0A4B; e2_b = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp_ph = (((k - 1) % 4) == 3) ? 3'b010 : 3'b100;
      if (k <= 12)
        check($sformatf("t6_phase_%0d", k), 32'({fetch_b, exec1_b, exec2_b}), 32'(exp_ph));
      if (k == 13) begin
        check("t6_ins_3", 32'(ins_b), 3);
        check("t6_cyc_12", 32'(cyc_b), 12);
      end
      if (k == 16) check("t6_cyc_sat", 32'(cyc_b), 15);
      if (k == 20) begin
        check("t6_cyc_hold", 32'(cyc_b), 15);
        check("t6_ins_4", 32'(ins_b), 4);
      end
    end
    check("t6_ins_sat", 32'(ins_b), 15);
    check("t6_cyc_final", 32'(cyc_b), 15);
    check("t6_running", 32'(running_b), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control-phase sequencer and instruction register for the 16-bit CPU.
- Sits directly upstream of the instruction decoder.
- Fetches each word from instruction RAM and holds it stable for the decoder.
- Drives the one-hot FETCH/EXEC1/EXEC2 phase strobes; takes E2 back from the decoder to decide whether a second execute cycle is needed.
- Stops on STP and keeps saturating cycle and instruction counters for debug.

Parameters:
FETCH_LAT, 1, cycles FETCH is held per instruction (instruction-RAM read latency); legal 1..4
CNT_W, 16, width of cycle_count and instr_count

Ports:
CLK  input  1  system clock, all state on rising edge
RSTn  input  1  synchronous active-low reset
RUN  input  1  level; 1 = execute, 0 = stop at next instruction boundary
instr_in  input  16  instruction-RAM read data
E2  input  1  decoder request for EXEC2; sampled only in EXEC1
FETCH  output  1  fetch phase strobe, also RAMi enable
EXEC1  output  1  first execute phase strobe
EXEC2  output  1  second execute phase strobe
instr  output  16  instruction register, to decoder
halted  output  1  STP executed; sticky until reset
running  output  1  state is not IDLE and not HALT
cycle_count  output  CNT_W  active cycles, saturating
instr_count  output  CNT_W  retired instructions, saturating

Behaviour:
- Reset applies when RSTn=0 at a rising CLK edge:
  - state=IDLE; FETCH=EXEC1=EXEC2=0; halted=0; running=0.
  - instr=16'h7C00 (NOP encoding); both counters=0; fetch counter=0.
  - Reset mid-instruction aborts that instruction; it is not counted.
- States: IDLE, FETCH, EXEC1, EXEC2, HALT.
  - FETCH, EXEC1, EXEC2 outputs are registered and one-hot.
  - All three are 0 in IDLE and HALT.
- IDLE: RUN=1 -> FETCH on the next cycle; otherwise stay.
- FETCH: held for exactly FETCH_LAT cycles, counted by an internal counter.
  - On the edge ending the last FETCH cycle: instr <= instr_in, then -> EXEC1.
  - instr changes only at this edge.
- EXEC1 is always exactly one cycle. Priority order at its end:
  - 1. instr is STP (instr[15]=0, instr[14:9]=6'b111111): -> HALT; halted<=1; instr_count+1.
  - 2. E2=1: -> EXEC2.
  - 3. Otherwise the instruction retires: instr_count+1, then -> FETCH if RUN=1, else IDLE.
- EXEC2 is always one cycle; the instruction retires: instr_count+1, then -> FETCH if RUN=1, else IDLE.
- RUN is checked only at instruction boundaries.
  - Dropping RUN during FETCH or EXEC1 never truncates the current instruction.
- HALT: absorbing; RUN ignored; exit only via reset.
- cycle_count: +1 on every cycle spent in FETCH, EXEC1 or EXEC2; holds at 2^CNT_W-1.
- instr_count: holds at 2^CNT_W-1.
- E2 outside EXEC1 has no effect.
  - E2=1 together with STP in EXEC1: STP wins; no EXEC2.
- Per-instruction latency:
  - Single-cycle instruction: FETCH_LAT+1 cycles.
  - LOAD/MUL/MLA/MLS/POP: FETCH_LAT+2 cycles.
  - Back-to-back instructions with no bubble while RUN=1.

Optional Feature:
- Macro: INSTR_SEQUENCER_STEP_EN.
- When defined:
  - Adds input STEP (1 bit) and input STEP_MODE (1 bit).
  - With STEP_MODE=1, each retire edge goes to IDLE regardless of RUN.
  - From IDLE, a rising edge of STEP starts exactly one instruction (edge-detected internally; level held high does not repeat).
  - STEP_MODE=0 behaves as the base block.
  - STEP is ignored in HALT.
- When undefined: no STEP/STEP_MODE ports; behaviour exactly as above.

Test Plan:
1. FETCH_LAT=1. Reset, RUN=1, instr_in=16'h0A4B (single-cycle ALU op), E2=0 -> FETCH,EXEC1 alternate. instr=16'h0A4B from cycle 2. After 10 active cycles: cycle_count=10, instr_count=5.
2. instr_in=16'h8005 (LOAD), decoder drives E2=1 in EXEC1 -> FETCH,EXEC1,EXEC2 repeat with period 3. instr_count +1 per 3 cycles.
3. instr_in=16'h7E00 (STP) with E2 forced 1 -> FETCH,EXEC1 then HALT. halted=1, running=0, instr_count=1. RUN toggling for 20 cycles leaves all outputs unchanged.
4. RUN dropped during EXEC1 of a LOAD -> EXEC2 still occurs, then IDLE; instr_count incremented once. RUN re-asserted -> FETCH next cycle.
5. RSTn=0 during EXEC2 -> next cycle: IDLE, instr=16'h7C00, counters=0, all strobes 0.
6. CNT_W=4, FETCH_LAT=3, continuous single-cycle ops -> FETCH held 3 cycles. cycle_count saturates at 15; instr_count reaches 3 and, with RUN kept high, eventually saturates at 15.
